// File: rtl/draw_pickups_if.sv
// VGA timing and colour bundle handed from one draw stage to the next.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_pickups.sv
// Overlays a row of SLOTS collectable sprites from one shared image ROM onto the VGA stream.
// Each slot runs its own pickup / blink / respawn state machine clocked by frame ticks.
module draw_pickups #(
  parameter int unsigned SLOTS          = 4,
  parameter int unsigned XPOS           = 800,
  parameter int unsigned YPOS           = 16,
  parameter int unsigned DX             = 24,
  parameter int unsigned SPR_W          = 16,
  parameter int unsigned SPR_H          = 16,
  parameter int unsigned BLINK_FRAMES   = 32,
  parameter int unsigned RESPAWN_FRAMES = 600,
  parameter logic [11:0] TRANSPARENT    = 12'hF0F,
  localparam int unsigned AW            = $clog2(SPR_W * SPR_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_game,
  input  logic             en,
  input  logic [SLOTS-1:0] picked_up,
  input  logic [11:0]      rgb_pixel,
  output logic [AW-1:0]    pixel_addr,
  output logic [SLOTS-1:0] active,
  vga_if.in                in,
  vga_if.out               out
);

  localparam int unsigned XW   = $clog2(SPR_W);
  localparam int unsigned YW   = AW - XW;
  localparam int unsigned SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CMAX = (BLINK_FRAMES > RESPAWN_FRAMES) ? BLINK_FRAMES : RESPAWN_FRAMES;
  localparam int unsigned CW   = (CMAX > 8) ? $clog2(CMAX) : 3;

  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] RESP_LAST  = (RESPAWN_FRAMES == 0) ? '0 : CW'(RESPAWN_FRAMES - 1);
  localparam logic [11:0]   Y_LO       = 12'(YPOS);
  localparam logic [11:0]   Y_HI       = 12'(YPOS + SPR_H);
  localparam logic [11:0]   W_12       = 12'(SPR_W);

  typedef enum logic [1:0] {IDLE, VISIBLE, BLINK, HIDDEN} slot_state_e;

  slot_state_e   state_q [SLOTS];
  slot_state_e   state_d [SLOTS];
  logic [CW-1:0] cnt_q   [SLOTS];
  logic [CW-1:0] cnt_d   [SLOTS];

  logic [11:0]      hc_c;
  logic [11:0]      vc_c;
  logic             row_hit_c;
  logic             hit_c;
  logic [SW-1:0]    slot_c;
  logic [AW-1:0]    addr_c;
  logic             adv_c;
  logic [SLOTS-1:0] vis_c;
  logic             draw_c;

  logic [10:0]   s1_vcount;
  logic [10:0]   s1_hcount;
  logic          s1_vsync;
  logic          s1_vblnk;
  logic          s1_hsync;
  logic          s1_hblnk;
  logic [11:0]   s1_rgb;
  logic          s1_hit;
  logic          s1_en;
  logic [SW-1:0] s1_slot;

  function automatic logic [11:0] slot_x(input int unsigned i);
    return 12'(XPOS + i * DX);
  endfunction

  assign hc_c = 12'(in.hcount);
  assign vc_c = 12'(in.vcount);

  // Hit test against every slot; the lowest index wins if slots ever overlap.
  always_comb begin
    hit_c     = 1'b0;
    slot_c    = '0;
    addr_c    = '0;
    row_hit_c = (vc_c >= Y_LO) && (vc_c < Y_HI);
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!hit_c && row_hit_c && (hc_c >= slot_x(i)) && (hc_c < slot_x(i) + W_12)) begin
        hit_c  = 1'b1;
        slot_c = SW'(i);
        addr_c = {YW'(vc_c - Y_LO), XW'(hc_c - slot_x(i))};
      end
    end
  end

  // Frame tick is the rising edge of vblnk; s1_vblnk doubles as the previous sample.
  assign adv_c = in.vblnk & ~s1_vblnk & en;

  // Per-slot next state; dropping start_game overrides everything else.
  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!start_game) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            state_d[i] = VISIBLE;
            cnt_d[i]   = '0;
          end
          VISIBLE: begin
            if (en && picked_up[i]) begin
              state_d[i] = BLINK;
              cnt_d[i]   = '0;
            end
          end
          BLINK: begin
            if (adv_c) begin
              if (cnt_q[i] == BLINK_LAST) begin
                state_d[i] = HIDDEN;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
              end
            end
          end
          HIDDEN: begin
            if (RESPAWN_FRAMES != 0 && adv_c) begin
              if (cnt_q[i] == RESP_LAST) begin
                state_d[i] = VISIBLE;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
              end
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      active <= '0;
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        active[i]  <= (state_q[i] == VISIBLE);
      end
    end
  end

  // Blinking slots show during the even 4-frame phases.
  always_comb begin
    vis_c = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      vis_c[i] = (state_q[i] == VISIBLE) || ((state_q[i] == BLINK) && !cnt_q[i][2]);
    end
  end

  assign draw_c = s1_hit && s1_en && vis_c[s1_slot] && (rgb_pixel != TRANSPARENT)
                  && !s1_hblnk && !s1_vblnk;

  // Two-stage pixel pipeline: stage 1 registers timing and ROM address, stage 2 picks the colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vcount  <= '0;
      s1_hcount  <= '0;
      s1_vsync   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_hsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_rgb     <= '0;
      s1_hit     <= 1'b0;
      s1_en      <= 1'b0;
      s1_slot    <= '0;
      pixel_addr <= '0;
      out.vcount <= '0;
      out.hcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      s1_vcount <= in.vcount;
      s1_hcount <= in.hcount;
      s1_vsync  <= in.vsync;
      s1_vblnk  <= in.vblnk;
      s1_hsync  <= in.hsync;
      s1_hblnk  <= in.hblnk;
      s1_rgb    <= in.rgb;
      s1_hit    <= hit_c;
      s1_en     <= en;
      s1_slot   <= slot_c;
      if (hit_c) begin
        pixel_addr <= addr_c;
      end
      out.vcount <= s1_vcount;
      out.hcount <= s1_hcount;
      out.vsync  <= s1_vsync;
      out.vblnk  <= s1_vblnk;
      out.hsync  <= s1_hsync;
      out.hblnk  <= s1_hblnk;
      out.rgb    <= draw_c ? rgb_pixel : s1_rgb;
    end
  end

endmodule

// File: tb/tb_draw_pickups.sv
// Bench for draw_pickups: directed scenarios plus random traffic, checked against a
// frame-counting reference model with a combinational ROM on the registered address.
module tb_draw_pickups;

  localparam int SLOTS = 4;
  localparam int XPOS  = 800;
  localparam int YPOS  = 16;
  localparam int DX    = 24;
  localparam int SPR_W = 16;
  localparam int SPR_H = 16;
  localparam int BLINK = 32;
  localparam int RESP  = 2;
  localparam logic [11:0] KEY   = 12'hF0F;
  localparam logic [11:0] GREEN = 12'h0F0;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } px_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_game;
  logic       en;
  logic [3:0] picked_up;
  logic [11:0] rgb_pixel;
  logic [7:0] pixel_addr;
  logic [3:0] active;
  logic [11:0] rom [256];

  vga_if vin ();
  vga_if vout ();

  draw_pickups #(.RESPAWN_FRAMES(RESP)) dut (
    .clk(clk), .rst(rst), .start_game(start_game), .en(en), .picked_up(picked_up),
    .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr), .active(active),
    .in(vin), .out(vout)
  );

  always #5 clk = ~clk;
  assign rgb_pixel = rom[pixel_addr];

  int total = 0;
  int bad   = 0;

  // Reference model: per slot "game on", "picked" and en-gated frames since pickup.
  bit   m_on   [SLOTS];
  bit   m_pick [SLOTS];
  int   m_age  [SLOTS];
  bit   m_prev_vblnk;
  px_t  pipe0, pipe1;
  logic [7:0] exp_addr;
  logic [3:0] exp_active;

  function automatic bit m_shown(input int i);
    if (!m_on[i]) return 1'b0;
    if (!m_pick[i]) return 1'b1;
    return (m_age[i] < BLINK) && ((m_age[i] / 4) % 2 == 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    px_t cur, e;
    int hc, vc, sl, a;
    bit tick;
    cur = {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync, vin.hblnk, vin.rgb};
    for (int i = 0; i < SLOTS; i++) exp_active[i] = !rst && m_on[i] && !m_pick[i];
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        m_on[i] = 0; m_pick[i] = 0; m_age[i] = 0;
      end
      pipe0 = '0; pipe1 = '0; exp_addr = '0;
    end else begin
      tick = vin.vblnk && !m_prev_vblnk;
      for (int i = 0; i < SLOTS; i++) begin
        if (!start_game) begin
          m_on[i] = 0; m_pick[i] = 0; m_age[i] = 0;
        end else if (!m_on[i]) begin
          m_on[i] = 1;
        end else if (m_pick[i]) begin
          if (tick && en) begin
            if (RESP != 0 || m_age[i] < BLINK) m_age[i]++;
            if (RESP != 0 && m_age[i] == BLINK + RESP) m_pick[i] = 0;
          end
        end else if (en && picked_up[i]) begin
          m_pick[i] = 1; m_age[i] = 0;
        end
      end
      hc = int'(vin.hcount);
      vc = int'(vin.vcount);
      sl = -1;
      for (int i = SLOTS - 1; i >= 0; i--)
        if (vc >= YPOS && vc < YPOS + SPR_H && hc >= XPOS + i * DX && hc < XPOS + i * DX + SPR_W)
          sl = i;
      e = cur;
      if (sl >= 0) begin
        a = (vc - YPOS) * SPR_W + hc - (XPOS + sl * DX);
        exp_addr = 8'(a);
        if (en && m_shown(sl) && rom[a] != KEY && !vin.hblnk && !vin.vblnk) e.rgb = rom[a];
      end
      pipe1 = pipe0;
      pipe0 = e;
    end
    m_prev_vblnk = !rst && vin.vblnk;
  endtask

  task automatic cycle();
    px_t obs;
    @(posedge clk);
    model_step();
    #1;
    obs = {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
    chk("out_stream", 64'(obs), 64'(pipe1));
    chk("active", 64'(active), 64'(exp_active));
    chk("pixel_addr", 64'(pixel_addr), 64'(exp_addr));
  endtask

  task automatic px(input int hc, input int vc, input bit hb, input bit vb, input logic [11:0] c);
    vin.hcount = 11'(hc);
    vin.vcount = 11'(vc);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = 1'($urandom);
    vin.vsync  = 1'($urandom);
    vin.rgb    = c;
    cycle();
  endtask

  task automatic filler();
    px(10, 2, 0, 0, 12'($urandom));
  endtask

  task automatic px_rand(input bit hb, input bit vb);
    px(796 + $urandom_range(95), 14 + $urandom_range(19), hb, vb, 12'($urandom));
  endtask

  // Drives one unblanked pixel and checks the colour that emerges two cycles later.
  task automatic probe(input string tag, input int hc, input int vc, input bit drawn);
    logic [11:0] bg;
    bg = 12'($urandom);
    if (bg == GREEN) bg = 12'h123;
    px(hc, vc, 0, 0, bg);
    filler();
    chk(tag, 64'(vout.rgb), 64'(drawn ? GREEN : bg));
  endtask

  task automatic fast_frame();
    for (int k = 0; k < 6; k++) px_rand(0, 0);
    for (int k = 0; k < 4; k++) px_rand(1'($urandom), 1);
    filler();
  endtask

  task automatic full_frame();
    for (int vc = 14; vc < 34; vc++) begin
      for (int hc = 796; hc < 892; hc++) px(hc, vc, 0, 0, 12'($urandom));
      for (int k = 0; k < 4; k++) px(800 + $urandom_range(87), vc, 1, 0, 12'($urandom));
    end
    for (int k = 0; k < 20; k++) px_rand(1'($urandom), 1);
    filler();
  endtask

  task automatic rand_frame();
    en = ($urandom_range(3) != 0);
    for (int k = 0; k < 10; k++) begin
      picked_up = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0;
      px_rand(0, 0);
    end
    picked_up = '0;
    for (int k = 0; k < 4; k++) px_rand(1'($urandom), 1);
    filler();
  endtask

  initial begin
    logic [11:0] bg;
    for (int i = 0; i < 256; i++) rom[i] = GREEN;
    rom[5] = KEY;
    rst = 1; start_game = 0; en = 0; picked_up = '0;
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 0; vin.vblnk = 0;
    vin.hsync = 0; vin.vsync = 0; vin.rgb = '0;

    // Reset, then an idle pass-through frame.
    repeat (3) px_rand(0, 0);
    chk("reset_rgb", 64'(vout.rgb), 64'd0);
    chk("reset_hcount", 64'(vout.hcount), 64'd0);
    chk("reset_active", 64'(active), 64'd0);
    rst = 0; en = 1;
    full_frame();

    // Game start: all slots collectable, edges and transparency.
    start_game = 1;
    filler(); filler();
    chk("start_active", 64'(active), 64'hF);
    probe("px_800_16", 800, 16, 1);
    probe("px_816_16", 816, 16, 0);
    bg = 12'h3A5;
    px(805, 16, 0, 0, bg);
    chk("addr_805_16", 64'(pixel_addr), 64'd5);
    filler();
    chk("px_805_16_key", 64'(vout.rgb), 64'(bg));
    probe("px_887_16", 887, 16, 1);
    probe("px_888_16", 888, 16, 0);
    probe("px_872_31", 872, 31, 1);
    probe("px_872_32", 872, 32, 0);
    full_frame();

    // Slot 1 pickup: blink every 4 frames, hidden 32..33, back at 34.
    picked_up = 4'b0010; filler();
    picked_up = 4'b0000; filler();
    chk("pick1_active", 64'(active), 64'hD);
    for (int f = 0; f < 36; f++) begin
      chk("pick1_frame_active", 64'(active), 64'((f >= BLINK + RESP) ? 4'hF : 4'hD));
      probe("slot1_blink", 830, 20, (f < BLINK && (f / 4) % 2 == 0) || f >= BLINK + RESP);
      fast_frame();
    end

    // Slot 2 pickup, then freeze with en=0 mid-blink; stray pulses must be ignored.
    picked_up = 4'b0100; filler();
    picked_up = 4'b0000; filler();
    for (int a = 0; a < 5; a++) begin
      probe("slot2_blink", 854, 20, (a / 4) % 2 == 0);
      fast_frame();
    end
    en = 0;
    for (int k = 0; k < 10; k++) begin
      picked_up = 4'hF; filler();
      picked_up = 4'h0; filler();
      chk("frozen_active", 64'(active), 64'hB);
      probe("frozen_slot0", 806, 20, 0);
      probe("frozen_slot2", 854, 20, 0);
      fast_frame();
    end
    en = 1;
    for (int a = 5; a < 12; a++) begin
      probe("slot2_resume", 854, 20, (a / 4) % 2 == 0);
      fast_frame();
    end
    probe("slot2_phase12", 854, 20, 0);

    // Drop start_game mid-blink, then restart.
    start_game = 0; filler(); filler();
    chk("stop_active", 64'(active), 64'h0);
    probe("stop_slot0", 806, 20, 0);
    start_game = 1; filler(); filler();
    chk("restart_active", 64'(active), 64'hF);
    probe("restart_slot2", 854, 20, 1);
    bg = 12'h5C3;
    px(806, 20, 1, 0, bg); filler();
    chk("hblnk_pass", 64'(vout.rgb), 64'(bg));
    bg = 12'h6D4;
    px(806, 20, 0, 1, bg); filler();
    chk("vblnk_pass", 64'(vout.rgb), 64'(bg));
    filler();
    full_frame();

    // Random ROM, pickups, enable and restarts.
    for (int i = 0; i < 256; i++) rom[i] = ($urandom_range(3) == 0) ? KEY : 12'($urandom);
    for (int f = 0; f < 60; f++) begin
      start_game = (f % 15 != 14);
      rand_frame();
    end
    en = 1; start_game = 1;
    full_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
